scale_autorepeat: RTL
=====================

Name: scale_autorepeat

Overview:
- Upstream control stage for the frequency divider.
- Consumes the two debounced push-button levels (plus/minus) and maintains the 6-bit frequency Scale word that the divider uses.
- A single press gives one step. A held button auto-repeats after a hold delay, then accelerates to a faster rate.
- Scale saturates at its bounds and never wraps. A one-cycle strobe marks every change so downstream stages can resynchronise.

Parameters:
- SCALE_W, 6, width of scale word; max value 2^SCALE_W-1.
- SCALE_RESET, 32, scale value after reset.
- HOLD_CYCLES, 25_000_000, cycles a button must stay held after the first step before auto-repeat starts (>=2).
- REPEAT_CYCLES, 5_000_000, cycles between slow auto-repeat steps (>=2).
- FAST_CYCLES, 1_000_000, cycles between fast auto-repeat steps (>=2, <=REPEAT_CYCLES).
- FAST_AFTER, 4, number of slow repeat steps before switching to fast rate (>=1).
- CNT_W, 25, width of the interval down-counter; must hold max(HOLD_CYCLES,REPEAT_CYCLES)-1.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Plus  in  1  debounced plus button level, active high, synchronous to sysclk.
- Minus  in  1  debounced minus button level, active high, synchronous to sysclk.
- Scale  out  SCALE_W  current frequency scale, registered.
- Scale_upd  out  1  one-cycle pulse in the cycle Scale shows a new value.
- Busy  out  1  high while any button is held (state != IDLE), registered.

Behaviour:
- Reset values: Scale=SCALE_RESET, Scale_upd=0, Busy=0, state=IDLE, counter=0, repeat count=0. Plus/Minus edge registers are cleared to 1, so a button held through reset is ignored until released.
- Edge detect: Plus_r and Minus_r register the inputs. A press means input=1 and the registered copy is 0.
- Step: dir=+1 for Plus, -1 for Minus.
  - Scale updates at the clock edge where the step is decided; latency from the sampled press to the new Scale is 1 cycle.
  - If the step would exceed max or go below 0, Scale is unchanged and Scale_upd stays 0. The FSM still advances.
- FSM states:
  - IDLE: press on exactly one button -> step, load counter=HOLD_CYCLES-1, go HOLD.
  - HOLD: counter decrements each cycle. At 0 with the same button still high -> step, counter=REPEAT_CYCLES-1, reps=1, go SLOW.
  - SLOW: at counter 0 -> step, reps+1.
    - If reps reaches FAST_AFTER, counter=FAST_CYCLES-1 and go FAST.
    - Otherwise counter=REPEAT_CYCLES-1.
  - FAST: at counter 0 -> step, counter=FAST_CYCLES-1.
  - LOCK: no steps. Go IDLE only when both Plus and Minus are low.
- Release: in HOLD/SLOW/FAST, the active button going low -> IDLE in the next cycle, with no step in that cycle. Releasing at counter 0 gives no step.
- Simultaneous events:
  - Both buttons pressed in the same cycle from IDLE -> LOCK, no step.
  - The other button rising while one is held -> LOCK, no further steps, Scale frozen.
- reps saturates at FAST_AFTER.
- Busy = (state != IDLE).
- reset mid-operation has the same effect as power-on reset; any step scheduled for that cycle is lost.

Decomposition:
- Shared package: FSM state encoding (IDLE, HOLD, SLOW, FAST, LOCK), SCALE_W, SCALE_RESET.
  - The divider and waveform stages import the same SCALE_W.
- One natural sub-module: interval_timer. This is the loadable down-counter with a terminal-count flag, parameterised on CNT_W and reused for HOLD/REPEAT/FAST.
- Step/saturation logic stays inline.

Test Plan:
All scenarios use HOLD=8, REPEAT=4, FAST=2, FAST_AFTER=3, SCALE_RESET=32 and SCALE_W=6 unless stated otherwise. Cycle 0 is the cycle Plus is first sampled high.
- Single tap: Plus high 3 cycles -> Scale=33 from cycle 1, exactly one Scale_upd pulse, Busy low again by cycle 4.
- Hold with acceleration: Plus high cycles 0..18 -> steps at 0, 8, 12, 16, 18. Scale sequence is 33, 34, 35, 36, 37, with 5 Scale_upd pulses and final Scale 37.
- Saturation high: reset with SCALE_RESET=62, hold Plus 30 cycles -> Scale 63 after the first step, then no further change and no further Scale_upd pulses. Minus tap -> 62.
- Saturation low: SCALE_RESET=0, tap Minus -> Scale stays 0, Scale_upd never asserts, Busy pulses.
- Both buttons: hold Plus to Scale 34, then raise Minus -> Scale frozen at 34 while both are high. Release only Plus -> no step. Release Minus -> IDLE, and the next Plus tap gives 35.
- Reset mid-hold: hold Plus, assert reset at cycle 10 for 1 cycle with Plus still high -> Scale=32 and no steps until Plus falls and rises again, then Scale=33.

Source files
------------

// File: rtl/scale_autorepeat_pkg.sv
// rtl/scale_autorepeat_pkg.sv - shared scale width, reset value and control FSM encoding
package scale_autorepeat_pkg;

    localparam int SCALE_W     = 6;
    localparam int SCALE_RESET = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        SLOW = 3'd2,
        FAST = 3'd3,
        LOCK = 3'd4
    } state_e;

endpackage

// File: rtl/scale_autorepeat_interval_timer.sv
// rtl/scale_autorepeat_interval_timer.sv - loadable down-counter with terminal-count flag
module interval_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/scale_autorepeat.sv
// rtl/scale_autorepeat.sv - plus/minus button auto-repeat control of the divider scale word
module scale_autorepeat #(
    parameter int SCALE_W       = scale_autorepeat_pkg::SCALE_W,
    parameter int SCALE_RESET   = scale_autorepeat_pkg::SCALE_RESET,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int FAST_CYCLES   = 1_000_000,
    parameter int FAST_AFTER    = 4,
    parameter int CNT_W         = 25
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               Plus,
    input  logic               Minus,
    output logic [SCALE_W-1:0] Scale,
    output logic               Scale_upd,
    output logic               Busy
);

    import scale_autorepeat_pkg::*;

    localparam int REP_W = $clog2(FAST_AFTER + 1);
    localparam logic [SCALE_W-1:0] SCALE_MAX = '1;

    state_e             state_q, state_d;
    logic [SCALE_W-1:0] scale_q, scale_d;
    logic               upd_q, upd_d;
    logic               up_q, up_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic               plus_r_q, minus_r_q;

    logic               press_p, press_m, active, other_rise;
    logic               step, load, tc;
    logic [CNT_W-1:0]   load_val;

    assign press_p    = Plus & ~plus_r_q;
    assign press_m    = Minus & ~minus_r_q;
    assign active     = up_q ? Plus : Minus;
    assign other_rise = up_q ? press_m : press_p;

    always_comb begin
        state_d  = state_q;
        up_d     = up_q;
        reps_d   = reps_q;
        step     = 1'b0;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            IDLE: begin
                if (press_p && press_m) begin
                    state_d = LOCK;
                end else if (press_p || press_m) begin
                    up_d     = press_p;
                    step     = 1'b1;
                    load     = 1'b1;
                    load_val = CNT_W'(HOLD_CYCLES - 1);
                    state_d  = HOLD;
                end
            end
            HOLD, SLOW, FAST: begin
                // A second button always wins over a release or a pending step.
                if (other_rise) begin
                    state_d = LOCK;
                end else if (!active) begin
                    state_d = IDLE;
                end else if (tc) begin
                    step = 1'b1;
                    load = 1'b1;
                    if (state_q == HOLD) begin
                        reps_d   = REP_W'(1);
                        load_val = CNT_W'(REPEAT_CYCLES - 1);
                        state_d  = (FAST_AFTER <= 1) ? FAST : SLOW;
                        if (FAST_AFTER <= 1) load_val = CNT_W'(FAST_CYCLES - 1);
                    end else if (state_q == SLOW) begin
                        reps_d = reps_q + 1'b1;
                        if (reps_d >= REP_W'(FAST_AFTER)) begin
                            load_val = CNT_W'(FAST_CYCLES - 1);
                            state_d  = FAST;
                        end else begin
                            load_val = CNT_W'(REPEAT_CYCLES - 1);
                        end
                    end else begin
                        load_val = CNT_W'(FAST_CYCLES - 1);
                    end
                end
            end
            LOCK: begin
                if (!Plus && !Minus) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scale_d = scale_q;
        upd_d   = 1'b0;
        if (step) begin
            if (up_d && scale_q != SCALE_MAX) begin
                scale_d = scale_q + 1'b1;
                upd_d   = 1'b1;
            end else if (!up_d && scale_q != '0) begin
                scale_d = scale_q - 1'b1;
                upd_d   = 1'b1;
            end
        end
    end

    interval_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk_i      (sysclk),
        .reset_i    (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .tc_o       (tc)
    );

    // Edge registers reset high so a button held through reset needs a fresh press.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= IDLE;
            scale_q   <= SCALE_W'(SCALE_RESET);
            upd_q     <= 1'b0;
            up_q      <= 1'b0;
            reps_q    <= '0;
            plus_r_q  <= 1'b1;
            minus_r_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            scale_q   <= scale_d;
            upd_q     <= upd_d;
            up_q      <= up_d;
            reps_q    <= reps_d;
            plus_r_q  <= Plus;
            minus_r_q <= Minus;
        end
    end

    assign Scale     = scale_q;
    assign Scale_upd = upd_q;
    assign Busy      = (state_q != IDLE);

endmodule
